// File: rtl/data_memory_pkg.sv
// Shared types and constants for the block-granular data memory responder.
// Imported by data_memory and mem_latency_counter.
package data_memory_pkg;

    localparam int DMEM_BLOCK_W         = 32;
    localparam int DMEM_ADDR_W          = 6;
    localparam int DMEM_DEFAULT_LATENCY = 5;
    localparam int DMEM_CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    // Access captured on the accepting edge; held stable for the whole BUSY phase.
    typedef struct packed {
        logic                    write;
        logic [DMEM_ADDR_W-1:0]  addr;
        logic [DMEM_BLOCK_W-1:0] data;
    } dmem_req_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the BUSY phase of a memory access.
// Saturates at zero; 'zero' flags the commit cycle.
module mem_latency_counter
    import data_memory_pkg::*;
#(
    parameter int W = DMEM_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_memory.sv
// Block data memory responding to the data cache with a fixed access latency.
// Optional commit trace under `DATA_MEMORY_TRACE_EN (simulation only).
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LATENCY = DMEM_DEFAULT_LATENCY,
    parameter int DEPTH   = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [DMEM_ADDR_W-1:0]  mem_address,
    input  logic [DMEM_BLOCK_W-1:0] mem_writedata,
    output logic [DMEM_BLOCK_W-1:0] mem_readdata,
    output logic                    mem_busywait
);

    localparam logic [DMEM_CNT_W-1:0] LOAD_VALUE = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e             state;
    dmem_state_e             next_state;
    dmem_req_t               req_q;
    logic [DMEM_BLOCK_W-1:0] mem_array [DEPTH];

    logic request;
    logic busy_comb;
    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;
    logic commit;

    assign request = mem_read | mem_write;

    mem_latency_counter #(
        .W (DMEM_CNT_W)
    ) u_latency_counter (
        .clk        (CLK),
        .rst        (RESET),
        .load       (cnt_load),
        .en         (cnt_en),
        .load_value (LOAD_VALUE),
        .zero       (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = BUSY;
            BUSY:    if (cnt_zero) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_comb = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                busy_comb = request;
                cnt_load  = request;
            end
            BUSY: begin
                busy_comb = 1'b1;
                cnt_en    = 1'b1;
                commit    = cnt_zero;
            end
            default: ;
        endcase
    end

    // Reset is async, so a request held across it would otherwise leak through IDLE.
    assign mem_busywait = busy_comb & ~RESET;

    // A simultaneous read and write resolves to a write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_q <= '0;
        end else if ((state == IDLE) && request) begin
            req_q.write <= mem_write;
            req_q.addr  <= mem_address;
            req_q.data  <= mem_writedata;
        end
    end

    // NOTE: the array is cleared by reset on purpose; this costs flops instead of RAM macros.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_array[i] <= '0;
            end
        end else if (commit && req_q.write) begin
            mem_array[req_q.addr] <= req_q.data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_readdata <= '0;
        end else if (commit && !req_q.write) begin
            mem_readdata <= mem_array[req_q.addr];
        end
    end

`ifdef DATA_MEMORY_TRACE_EN
    always @(posedge CLK) begin
        if (!RESET && commit) begin
            $display("%0t data_memory %s addr=%0d data=%h", $time,
                     req_q.write ? "W" : "R", req_q.addr,
                     req_q.write ? req_q.data : mem_array[req_q.addr]);
        end
    end
`else
    // Trace disabled: no trace logic is compiled.
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver queues expected acknowledges,
// a negedge monitor measures each busywait run and checks read data at the ack.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int LAT      = 5;
    localparam int BUSY_CYC = LAT + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [5:0]  mem_address = '0;
    logic [31:0] mem_writedata = '0;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] rdata;
        int          busy;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    data_memory #(
        .LATENCY (LAT),
        .DEPTH   (64)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busywait run ending in a low cycle is one acknowledge.
    int run = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            run = 0;
        end else if (mem_busywait === 1'b1) begin
            run++;
        end else if (run > 0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ack: got ack after %0d busy cycles expected none", run);
            end else begin
                e = sb_q.pop_front();
                check({e.name, " busy_len"}, 32'(run), 32'(e.busy));
                check({e.name, " rdata"}, mem_readdata, e.rdata);
            end
            run = 0;
        end
    end

    // One access; perturb rewrites address/data to 11/0 in cycle 2 while still requesting.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [5:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input bit perturb);
        int hold = perturb ? 3 : 1;
        sb_q.push_back('{exp_rd, BUSY_CYC, name});
        @(posedge CLK); #1;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge CLK); #1;
            if (perturb && cyc == 2) begin
                mem_address   = 6'd11;
                mem_writedata = '0;
            end
            if (cyc == hold) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            if (!mem_busywait) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL %s timeout: got busywait stuck high expected ack within 40 cycles", name);
    endtask

    task automatic wait_ack(input string name);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge CLK); #1;
            if (!mem_busywait) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL %s timeout: got busywait stuck high expected ack within 40 cycles", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with a request held to show busywait is forced low.
        mem_read = 1'b1;
        #12;
        check("reset busywait", 32'(mem_busywait), 32'd0);
        check("reset rdata", mem_readdata, 32'h0);
        mem_read = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;

        access("wr5",        1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 32'h0,        1'b0);
        access("rd5",        1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF, 1'b0);
        access("rd63",       1'b1, 1'b0, 6'd63, 32'h0,        32'h0,        1'b0);
        access("wr10_pert",  1'b0, 1'b1, 6'd10, 32'hCAFEF00D, 32'h0,        1'b1);
        access("rd10",       1'b1, 1'b0, 6'd10, 32'h0,        32'hCAFEF00D, 1'b0);
        access("rd11",       1'b1, 1'b0, 6'd11, 32'h0,        32'h0,        1'b0);
        access("rd5_again",  1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF, 1'b0);
        access("rdwr3",      1'b1, 1'b1, 6'd3,  32'h12345678, 32'hDEADBEEF, 1'b0);
        access("rd3",        1'b1, 1'b0, 6'd3,  32'h0,        32'h12345678, 1'b0);

        // Reset pulse in cycle 3 of a write to 7: aborts with no commit.
        @(posedge CLK); #1;
        mem_write     = 1'b1;
        mem_address   = 6'd7;
        mem_writedata = 32'hA5A5A5A5;
        repeat (3) @(posedge CLK);
        #3;
        RESET     = 1'b1;
        mem_write = 1'b0;
        #1;
        check("abort busywait", 32'(mem_busywait), 32'd0);
        check("abort state", 32'(dut.state), 32'(IDLE));
        check("abort rdata", mem_readdata, 32'h0);
        @(negedge CLK);
        #2;
        RESET = 1'b0;

        access("rd7_after_rst", 1'b1, 1'b0, 6'd7, 32'h0,        32'h0, 1'b0);
        access("rd3_after_rst", 1'b1, 1'b0, 6'd3, 32'h0,        32'h0, 1'b0);
        access("wr3",           1'b0, 1'b1, 6'd3, 32'h0BADF00D, 32'h0, 1'b0);

        // Read held across two accesses: one ack cycle, restart on the next.
        sb_q.push_back('{32'h0BADF00D, BUSY_CYC, "b2b_1"});
        sb_q.push_back('{32'h0BADF00D, BUSY_CYC, "b2b_2"});
        @(posedge CLK); #1;
        mem_read    = 1'b1;
        mem_address = 6'd3;
        wait_ack("b2b_1");
        @(posedge CLK); #1;
        check("b2b restart busywait", 32'(mem_busywait), 32'd1);
        @(posedge CLK); #1;
        mem_read = 1'b0;
        wait_ack("b2b_2");

        repeat (3) @(posedge CLK);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
